// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer: PC sequencing controller. Handles variable-length fetch,
// branch/loop/jump/return decisions and prioritised vectored interrupts.
// Revision: 1.0
// ============================================================================
module pc_sequencer #(
  parameter int MAX_LEN  = 2,
  parameter int NUM_IRQ  = 4,
  parameter int VEC_BASE = 1,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [3:0]         opcode,
  input  logic [1:0]         brx,
  input  logic [LEN_W-1:0]   instr_len,
  input  logic               z_flag,
  input  logic               n_flag,
  input  logic               c_flag,
  input  logic               v_flag,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               irq_en,
  output logic               pc_en,
  output logic               pc_load,
  output logic [1:0]         pc_src,
  output logic [1:0]         addr_src,
  output logic [IDX_W-1:0]   vec_idx,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               flush,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_FETCH     = 3'd1,
    S_FETCH_EXT = 3'd2,
    S_DONE      = 3'd3,
    S_IRQ       = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               loaded_q, loaded_d;
  logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;

  logic [LEN_W-1:0]   eff_len;
  logic               irq_pending;
  logic [IDX_W-1:0]   irq_winner;
  logic               cond;
  logic               pc_loaded;
  logic               frozen;

  // VEC_BASE is added by the downstream address mux; only the index leaves here.
  logic unused_vec_base;
  assign unused_vec_base = (VEC_BASE != 0);

  always_comb begin
    if (instr_len == '0 || instr_len > LEN_W'(MAX_LEN)) begin
      eff_len = LEN_W'(1);
    end else begin
      eff_len = instr_len;
    end
  end

  // Lowest-index request wins.
  always_comb begin
    irq_winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) begin
        irq_winner = IDX_W'(i);
      end
    end
  end

  assign irq_pending = irq_en && (|irq_req);

  always_comb begin
    case (brx)
      2'd0:    cond = z_flag;
      2'd1:    cond = n_flag;
      2'd2:    cond = c_flag;
      default: cond = v_flag;
    endcase
  end

  assign frozen = stall && (state_q != S_RESET);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    loaded_d  = loaded_q;
    vec_idx_d = vec_idx_q;
    irq_ack_d = '0;
    pc_en     = 1'b0;
    pc_load   = 1'b0;
    pc_src    = 2'b00;
    addr_src  = 2'b00;
    flush     = 1'b0;
    pc_loaded = 1'b0;

    case (state_q)
      S_RESET: begin
        pc_en    = 1'b1;
        pc_load  = 1'b1;
        pc_src   = 2'b01;
        addr_src = 2'b01;
        loaded_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        pc_en    = !loaded_q;
        cnt_d    = eff_len - LEN_W'(1);
        loaded_d = 1'b0;
        state_d  = (eff_len > LEN_W'(1)) ? S_FETCH_EXT : S_DONE;
      end
      S_FETCH_EXT: begin
        pc_en = 1'b1;
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q <= LEN_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_FETCH;
        if (irq_pending) begin
          state_d   = S_IRQ;
          vec_idx_d = irq_winner;
          irq_ack_d = NUM_IRQ'(1) << irq_winner;
        end else if ((opcode == 4'd9 && cond) || (opcode == 4'd10 && !z_flag)) begin
          pc_loaded = 1'b1;
          pc_src    = 2'b00;
        end else if (opcode == 4'd11) begin
          pc_loaded = 1'b1;
          pc_src    = {1'b1, brx[1]};
        end
        if (pc_loaded) begin
          pc_en    = 1'b1;
          pc_load  = 1'b1;
          flush    = 1'b1;
          loaded_d = 1'b1;
        end
      end
      S_IRQ: begin
        pc_en    = 1'b1;
        pc_load  = 1'b1;
        pc_src   = 2'b01;
        addr_src = 2'b10;
        flush    = 1'b1;
        loaded_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase

    // A stalled S_IRQ keeps its pending acknowledge for when the stall lifts.
    if (frozen) begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      loaded_d  = loaded_q;
      vec_idx_d = vec_idx_q;
      irq_ack_d = irq_ack_q;
      pc_en     = 1'b0;
      pc_load   = 1'b0;
      flush     = 1'b0;
    end

    if (reset) begin
      state_d   = S_RESET;
      cnt_d     = '0;
      loaded_d  = 1'b1;
      vec_idx_d = '0;
      irq_ack_d = '0;
      pc_en     = 1'b1;
      pc_load   = 1'b1;
      pc_src    = 2'b01;
      addr_src  = 2'b01;
      flush     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    loaded_q  <= loaded_d;
    vec_idx_q <= vec_idx_d;
    irq_ack_q <= irq_ack_d;
  end

  assign irq_ack = (reset || frozen) ? '0 : irq_ack_q;
  assign vec_idx = reset ? '0 : vec_idx_q;
  assign busy    = reset || (state_q != S_FETCH);

endmodule
`default_nettype wire
